// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl: in-order issue controller wrapped around an external
// combinational decoder. It buffers fetched instructions in a circular queue
// and presents the head entry to the decoder. A 32-entry busy scoreboard holds
// the head until its source and destination registers have no pending write.
// Define DECODE_ISSUE_PERF_EN to add the o_stall_cnt hazard-stall counter.
module decode_issue_ctrl #(
  parameter int QDEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_instr,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [31:0] o_dec_instr,
  input  logic [14:0] i_dec_regs,
  output logic        o_issue_valid,
  input  logic        i_issue_ready,
  output logic [31:0] o_issue_instr,
  output logic [14:0] o_issue_regs,
  input  logic        i_wb_en,
  input  logic [4:0]  i_wb_rd,
  input  logic        i_flush
`ifdef DECODE_ISSUE_PERF_EN
  ,
  output logic [31:0] o_stall_cnt
`endif
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } issueState_t;

  logic [31:0]   mem_q [QDEPTH];
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   busy_q, busy_d;

  issueState_t   state;
  logic          hazard;
  logic          doEnq;
  logic          doIssue;
  logic [4:0]    decRs1;
  logic [4:0]    decRs2;
  logic [4:0]    decRd;

  assign decRs1 = i_dec_regs[4:0];
  assign decRs2 = i_dec_regs[9:5];
  assign decRd  = i_dec_regs[14:10];

  // Derive the issue state from occupancy and the registered scoreboard only,
  // so a writeback this cycle cannot release the head until the next cycle.
  always_comb begin
    hazard = busy_q[decRs1] | busy_q[decRs2] | busy_q[decRd];
    state  = EMPTY;
    if (count_q != '0) begin
      state = hazard ? WAIT : READY;
    end
  end

  // Drive the decoder and execute-side outputs; an empty queue shows a NOP.
  always_comb begin
    o_ready       = (count_q != CW'(QDEPTH));
    o_dec_instr   = NOP;
    o_issue_instr = NOP;
    o_issue_regs  = '0;
    o_issue_valid = 1'b0;
    if (state != EMPTY) begin
      o_dec_instr   = mem_q[rdPtr_q];
      o_issue_instr = mem_q[rdPtr_q];
      o_issue_regs  = i_dec_regs;
    end
    if (state == READY && !i_flush) begin
      o_issue_valid = 1'b1;
    end
  end

  assign doEnq   = i_valid & o_ready & ~i_flush;
  assign doIssue = o_issue_valid & i_issue_ready;

  // Next queue pointers, occupancy and scoreboard; an issue marking rd busy
  // overrides a same-cycle writeback clearing it because it is the newer write.
  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    busy_d  = busy_q;
    if (i_flush) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (doEnq) begin
        wrPtr_d = wrPtr_q + PW'(1);
      end
      if (doIssue) begin
        rdPtr_d = rdPtr_q + PW'(1);
      end
      count_d = count_q + CW'(doEnq) - CW'(doIssue);
    end
    if (i_wb_en) begin
      busy_d[i_wb_rd] = 1'b0;
    end
    if (doIssue && decRd != 5'd0) begin
      busy_d[decRd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Queue control and scoreboard registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
      busy_q  <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
      busy_q  <= busy_d;
    end
  end

  // Queue storage, written at the tail on each accepted enqueue.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        mem_q[i] <= NOP;
      end
    end else if (doEnq) begin
      mem_q[wrPtr_q] <= i_instr;
    end
  end

`ifdef DECODE_ISSUE_PERF_EN
  logic [31:0] stallCnt_q, stallCnt_d;

  // Count cycles where a present head is blocked by a hazard, saturating.
  always_comb begin
    stallCnt_d = stallCnt_q;
    if (state == WAIT && !i_flush && stallCnt_q != 32'hFFFFFFFF) begin
      stallCnt_d = stallCnt_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stallCnt_q <= '0;
    end else begin
      stallCnt_q <= stallCnt_d;
    end
  end

  assign o_stall_cnt = stallCnt_q;
`endif

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// tb_decode_issue_ctrl: directed self-checking bench for decode_issue_ctrl.
// Includes a small behavioural decoder feeding the DUT's i_dec_regs input.
module tb_decode_issue_ctrl;

  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [31:0] ADDI1  = 32'h00100093;
  localparam logic [31:0] ADDX2  = 32'h00108133;
  localparam logic [31:0] ADDI3  = 32'h00300193;
  localparam logic [31:0] ADDI4  = 32'h00400213;
  localparam logic [31:0] ADDI5  = 32'h00500293;

  logic        clock;
  logic        rstN;
  logic [31:0] instr;
  logic        valid;
  logic        ready;
  logic [31:0] decInstr;
  logic [14:0] decRegs;
  logic        issueValid;
  logic        issueReady;
  logic [31:0] issueInstr;
  logic [14:0] issueRegs;
  logic        wbEn;
  logic [4:0]  wbRd;
  logic        flush;
`ifdef DECODE_ISSUE_PERF_EN
  logic [31:0] stallCnt;
`endif

  int assertCount;
  int failCount;

  decode_issue_ctrl #(.QDEPTH(2)) dut (
    .i_clk         (clock),
    .i_rst_n       (rstN),
    .i_instr       (instr),
    .i_valid       (valid),
    .o_ready       (ready),
    .o_dec_instr   (decInstr),
    .i_dec_regs    (decRegs),
    .o_issue_valid (issueValid),
    .i_issue_ready (issueReady),
    .o_issue_instr (issueInstr),
    .o_issue_regs  (issueRegs),
    .i_wb_en       (wbEn),
    .i_wb_rd       (wbRd),
    .i_flush       (flush)
`ifdef DECODE_ISSUE_PERF_EN
    ,
    .o_stall_cnt   (stallCnt)
`endif
  );

  // Behavioural decoder: packs {rd,rs2,rs1}, zeroing fields the format lacks.
  function automatic logic [14:0] decodeRegs(input logic [31:0] ins);
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    rd  = ins[11:7];
    rs1 = ins[19:15];
    rs2 = ins[24:20];
    case (ins[6:0])
      7'h13, 7'h03, 7'h67: decodeRegs = {rd, 5'd0, rs1};
      7'h23, 7'h63:        decodeRegs = {5'd0, rs2, rs1};
      default:             decodeRegs = {rd, rs2, rs1};
    endcase
  endfunction

  assign decRegs = decodeRegs(decInstr);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] ins,
                               input logic rdy, input logic we,
                               input logic [4:0] wr, input logic fl);
    valid      = v;
    instr      = ins;
    issueReady = rdy;
    wbEn       = we;
    wbRd       = wr;
    flush      = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    rstN = 1'b0;
    applyStimulus(1'b0, NOP, 1'b0, 1'b0, 5'd0, 1'b0);

    // 1: reset values, then a single addi x1 issuing one cycle after enqueue
    checkOutput("rst_ready", 32'(ready), 32'd1);
    checkOutput("rst_ivalid", 32'(issueValid), 32'd0);
    checkOutput("rst_dec", decInstr, NOP);
    checkOutput("rst_iinstr", issueInstr, NOP);
    checkOutput("rst_iregs", 32'(issueRegs), 32'd0);
`ifdef DECODE_ISSUE_PERF_EN
    checkOutput("rst_stall", stallCnt, 32'd0);
`endif
    #10 rstN = 1'b1;
    tick();
    applyStimulus(1'b1, ADDI1, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("t1_empty_ivalid", 32'(issueValid), 32'd0);
    tick();
    applyStimulus(1'b0, NOP, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("t1_ivalid", 32'(issueValid), 32'd1);
    checkOutput("t1_iinstr", issueInstr, ADDI1);
    checkOutput("t1_iregs", 32'(issueRegs), 32'h0400);
    tick();
    checkOutput("t1_drained", 32'(issueValid), 32'd0);
    checkOutput("t1_dec_nop", decInstr, NOP);

    // 2: add x2,x1,x1 waits on busy x1 until the cycle after writeback
    applyStimulus(1'b1, ADDX2, 1'b1, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b0, NOP, 1'b1, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t2_hold", 32'(issueValid), 32'd0);
      tick();
    end
    applyStimulus(1'b0, NOP, 1'b1, 1'b1, 5'd1, 1'b0);
    checkOutput("t2_wb_nobypass", 32'(issueValid), 32'd0);
    tick();
    applyStimulus(1'b0, NOP, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("t2_release", 32'(issueValid), 32'd1);
    checkOutput("t2_iregs", 32'(issueRegs), 32'h0821);
`ifdef DECODE_ISSUE_PERF_EN
    checkOutput("t2_stall_cnt", stallCnt, 32'd4);
`endif
    tick();
    applyStimulus(1'b0, NOP, 1'b0, 1'b1, 5'd2, 1'b0);
    tick();

    // 3: fill the queue with issue blocked, then drain across pointer wrap
    applyStimulus(1'b1, ADDI3, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("t3_ready0", 32'(ready), 32'd1);
    tick();
    applyStimulus(1'b1, ADDI4, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("t3_ready1", 32'(ready), 32'd1);
    tick();
    applyStimulus(1'b1, ADDI5, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("t3_full", 32'(ready), 32'd0);
    checkOutput("t3_head", decInstr, ADDI3);
    tick();
    applyStimulus(1'b1, ADDI5, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("t3_nobypass", 32'(ready), 32'd0);
    checkOutput("t3_issue_a", issueInstr, ADDI3);
    tick();
    applyStimulus(1'b1, ADDI5, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("t3_ready_again", 32'(ready), 32'd1);
    checkOutput("t3_issue_b", issueInstr, ADDI4);
    tick();
    applyStimulus(1'b0, NOP, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("t3_wrap_valid", 32'(issueValid), 32'd1);
    checkOutput("t3_wrap_head", issueInstr, ADDI5);
    tick();
    checkOutput("t3_empty", 32'(issueValid), 32'd0);
    applyStimulus(1'b0, NOP, 1'b0, 1'b1, 5'd3, 1'b0);
    tick();
    applyStimulus(1'b0, NOP, 1'b0, 1'b1, 5'd4, 1'b0);
    tick();
    applyStimulus(1'b0, NOP, 1'b0, 1'b1, 5'd5, 1'b0);
    tick();

    // 4: flush a full queue; dropped enqueue, busy x1 survives the flush
    applyStimulus(1'b1, ADDI1, 1'b1, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b0, NOP, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("t4_x1_issue", 32'(issueValid), 32'd1);
    tick();
    applyStimulus(1'b1, ADDX2, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b1, ADDI4, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b1, ADDI5, 1'b1, 1'b0, 5'd0, 1'b1);
    checkOutput("t4_full", 32'(ready), 32'd0);
    checkOutput("t4_flush_noissue", 32'(issueValid), 32'd0);
    tick();
    applyStimulus(1'b0, NOP, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("t4_flush_nop", decInstr, NOP);
    checkOutput("t4_flush_ready", 32'(ready), 32'd1);
    checkOutput("t4_flush_ivalid", 32'(issueValid), 32'd0);
    applyStimulus(1'b1, ADDX2, 1'b1, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b0, NOP, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("t4_busy_kept", 32'(issueValid), 32'd0);
    tick();
    applyStimulus(1'b0, NOP, 1'b1, 1'b1, 5'd1, 1'b0);
    checkOutput("t4_wb_cycle", 32'(issueValid), 32'd0);
    tick();
    applyStimulus(1'b0, NOP, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("t4_after_wb", 32'(issueValid), 32'd1);
    checkOutput("t4_after_wb_instr", issueInstr, ADDX2);
    tick();
    applyStimulus(1'b0, NOP, 1'b0, 1'b1, 5'd2, 1'b0);
    tick();

    // 5: same-cycle issue and writeback of x5 leaves x5 busy; x0 never stalls
    applyStimulus(1'b1, ADDI5, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b0, NOP, 1'b1, 1'b1, 5'd5, 1'b0);
    checkOutput("t5_issue_x5", 32'(issueValid), 32'd1);
    tick();
    applyStimulus(1'b1, ADDI5, 1'b1, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b0, NOP, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("t5_set_wins", 32'(issueValid), 32'd0);
    tick();
    applyStimulus(1'b0, NOP, 1'b1, 1'b1, 5'd5, 1'b0);
    tick();
    applyStimulus(1'b0, NOP, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("t5_x5_release", 32'(issueValid), 32'd1);
    tick();
    applyStimulus(1'b1, NOP, 1'b1, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b1, NOP, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("t5_x0_a", 32'(issueValid), 32'd1);
    tick();
    applyStimulus(1'b0, NOP, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("t5_x0_b", 32'(issueValid), 32'd1);
    tick();

    // 6: asynchronous reset mid-stream clears queue and scoreboard at once
    applyStimulus(1'b1, ADDI3, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b0, NOP, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("t6_pre_valid", 32'(issueValid), 32'd1);
    checkOutput("t6_pre_head", decInstr, ADDI3);
    #1 rstN = 1'b0;
    #1;
    checkOutput("t6_rst_ivalid", 32'(issueValid), 32'd0);
    checkOutput("t6_rst_dec", decInstr, NOP);
    checkOutput("t6_rst_ready", 32'(ready), 32'd1);
    checkOutput("t6_rst_iregs", 32'(issueRegs), 32'd0);
    #2 rstN = 1'b1;
    tick();
    checkOutput("t6_still_empty", 32'(issueValid), 32'd0);
    applyStimulus(1'b1, ADDI5, 1'b1, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b0, NOP, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("t6_busy_clr", 32'(issueValid), 32'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
